// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave register bank: FSM encoding,
// default address width and a width helper for parameterised ports.
package i2c_slave_pkg;

  localparam int DEFAULT_ADDRESSLENGTH = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR,
    S_WRITE,
    S_READ,
    S_IGNORE
  } state_t;

  // Bits needed to index n items, never less than one so ports stay legal.
  function automatic int clog2Min1(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_addr_match.sv
// Combinational priority matcher: compares a received slave address against
// a packed list and reports a hit plus the lowest matching entry index.
module i2c_addr_match
  import i2c_slave_pkg::*;
#(
  parameter  int ADDRESSLENGTH = DEFAULT_ADDRESSLENGTH,
  parameter  int ADDRESSNUM    = 4,
  localparam int IW            = clog2Min1(ADDRESSNUM)
) (
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] i_addressList,
  input  logic [ADDRESSLENGTH-1:0]            i_address,
  output logic                                o_hit,
  output logic [IW-1:0]                       o_index
);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    o_hit   = 1'b0;
    o_index = '0;
    for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
      if (i_addressList[i*ADDRESSLENGTH +: ADDRESSLENGTH] == i_address) begin
        o_hit   = 1'b1;
        o_index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C slave register bank: one private byte bank per served device address,
// a shared auto-incrementing pointer and a registered ACK/transmit interface.
module i2c_slave_regbank
  import i2c_slave_pkg::*;
#(
  parameter  int ADDRESSLENGTH = DEFAULT_ADDRESSLENGTH,
  parameter  int ADDRESSNUM    = 4,
  parameter  int NBYTES        = 16,
  localparam int PW            = clog2Min1(NBYTES),
  localparam int IW            = clog2Min1(ADDRESSNUM)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] i_addressList,
  input  logic                                i_startDet,
  input  logic                                i_stopDet,
  input  logic                                i_addrValid,
  input  logic [ADDRESSLENGTH-1:0]            i_directionBuffer,
  input  logic                                i_rorW,
  input  logic                                i_rxValid,
  input  logic [7:0]                          i_inputBuffer,
  input  logic                                i_txReq,
  output logic                                o_addressFound,
  output logic [IW-1:0]                       o_matchId,
  output logic                                o_ack,
  output logic [7:0]                          o_outputBuffer,
  output logic                                o_txValid
);

  state_t        r_state;
  logic [PW-1:0] r_ptr;
  logic [IW-1:0] r_matchId;
  logic          r_addressFound;
  logic          r_ack;
  logic [7:0]    r_outputBuffer;
  logic          r_txValid;
  logic [7:0]    r_bank [ADDRESSNUM][NBYTES];

  logic          w_hit;
  logic [IW-1:0] w_index;
  logic [PW-1:0] w_ptrNext;
  logic          w_ptrInRange;

  i2c_addr_match #(
    .ADDRESSLENGTH(ADDRESSLENGTH),
    .ADDRESSNUM   (ADDRESSNUM)
  ) u_match (
    .i_addressList(i_addressList),
    .i_address    (i_directionBuffer),
    .o_hit        (w_hit),
    .o_index      (w_index)
  );

  assign w_ptrNext    = (r_ptr == PW'(NBYTES - 1)) ? '0 : r_ptr + PW'(1);
  assign w_ptrInRange = int'({24'd0, i_inputBuffer}) < NBYTES;

  // START/STOP outrank everything else, so a coincident data byte is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_matchId      <= '0;
      r_addressFound <= 1'b0;
      r_ack          <= 1'b0;
      r_outputBuffer <= 8'h00;
      r_txValid      <= 1'b0;
      for (int b = 0; b < ADDRESSNUM; b++)
        for (int j = 0; j < NBYTES; j++)
          r_bank[b][j] <= 8'h00;
    end else begin
      r_txValid <= 1'b0;
      if (i_stopDet || i_startDet) begin
        r_state <= S_IDLE;
        if (i_stopDet) r_addressFound <= 1'b0;
      end else if (i_addrValid) begin
        r_addressFound <= w_hit;
        r_ack          <= w_hit;
        if (w_hit) begin
          r_matchId <= w_index;
          r_state   <= i_rorW ? S_PTR : S_READ;
        end else begin
          r_state <= S_IGNORE;
        end
      end else begin
        case (r_state)
          S_PTR: begin
            if (i_rxValid) begin
              r_ack <= w_ptrInRange;
              if (w_ptrInRange) begin
                r_ptr   <= i_inputBuffer[PW-1:0];
                r_state <= S_WRITE;
              end else begin
                r_state <= S_IGNORE;
              end
            end else if (i_txReq) begin
              r_ack <= 1'b0;
            end
          end
          S_WRITE: begin
            if (i_rxValid) begin
              r_bank[r_matchId][r_ptr] <= i_inputBuffer;
              r_ack                    <= 1'b1;
              r_ptr                    <= w_ptrNext;
            end else if (i_txReq) begin
              r_ack <= 1'b0;
            end
          end
          S_READ: begin
            if (i_txReq) begin
              r_outputBuffer <= r_bank[r_matchId][r_ptr];
              r_txValid      <= 1'b1;
              r_ptr          <= w_ptrNext;
            end else if (i_rxValid) begin
              r_ack <= 1'b0;
            end
          end
          default: begin
            // Unaddressed traffic: NACK writes, answer reads with idle-bus 0xFF.
            if (i_rxValid || i_txReq) r_ack <= 1'b0;
            if (i_txReq) begin
              r_outputBuffer <= 8'hFF;
              r_txValid      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign o_addressFound = r_addressFound;
  assign o_matchId      = r_matchId;
  assign o_ack          = r_ack;
  assign o_outputBuffer = r_outputBuffer;
  assign o_txValid      = r_txValid;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed scoreboard bench for i2c_slave_regbank with two served addresses
// (0x50 -> bank 0, 0x51 -> bank 1) of four bytes each.
module tb_i2c_slave_regbank;

  logic        clk;
  logic        rstN;
  logic [13:0] addressList;
  logic        startDet;
  logic        stopDet;
  logic        addrValid;
  logic [6:0]  directionBuffer;
  logic        rorW;
  logic        rxValid;
  logic [7:0]  inputBuffer;
  logic        txReq;
  logic        addressFound;
  logic [0:0]  matchId;
  logic        ack;
  logic [7:0]  outputBuffer;
  logic        txValid;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  expQ [$];

  i2c_slave_regbank #(
    .ADDRESSLENGTH(7),
    .ADDRESSNUM   (2),
    .NBYTES       (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_addressList    (addressList),
    .i_startDet       (startDet),
    .i_stopDet        (stopDet),
    .i_addrValid      (addrValid),
    .i_directionBuffer(directionBuffer),
    .i_rorW           (rorW),
    .i_rxValid        (rxValid),
    .i_inputBuffer    (inputBuffer),
    .i_txReq          (txReq),
    .o_addressFound   (addressFound),
    .o_matchId        (matchId),
    .o_ack            (ack),
    .o_outputBuffer   (outputBuffer),
    .o_txValid        (txValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every transmitted byte is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (rstN && txValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL unexpectedTx: observed=%0h expected=none", outputBuffer);
      end else begin
        checkOutput("txData", {24'd0, outputBuffer}, {24'd0, expQ.pop_front()});
      end
    end
  end

  task automatic applyStimulus(input logic start, input logic stop, input logic av,
                               input logic [6:0] addr, input logic rw, input logic rx,
                               input logic [7:0] data, input logic tx);
    startDet        = start;
    stopDet         = stop;
    addrValid       = av;
    directionBuffer = addr;
    rorW            = rw;
    rxValid         = rx;
    inputBuffer     = data;
    txReq           = tx;
    @(negedge clk);
    startDet  = 1'b0;
    stopDet   = 1'b0;
    addrValid = 1'b0;
    rxValid   = 1'b0;
    txReq     = 1'b0;
  endtask

  task automatic startC();
    applyStimulus(1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic stopC();
    applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendAddr(input logic [6:0] a, input logic rw);
    applyStimulus(1'b0, 1'b0, 1'b1, a, rw, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic readByte(input logic [7:0] exp);
    expQ.push_back(exp);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("txValid", {31'd0, txValid}, 32'd1);
  endtask

  // Write-pointer then repeated-START read of the given address.
  task automatic pointedRead(input logic [6:0] a, input logic [7:0] p);
    startC();
    sendAddr(a, 1'b1);
    sendByte(p);
    startC();
    sendAddr(a, 1'b0);
  endtask

  initial begin
    addressList     = {7'h51, 7'h50};
    rstN            = 1'b1;
    startDet        = 1'b0;
    stopDet         = 1'b0;
    addrValid       = 1'b0;
    directionBuffer = 7'h00;
    rorW            = 1'b0;
    rxValid         = 1'b0;
    inputBuffer     = 8'h00;
    txReq           = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstFound", {31'd0, addressFound}, 32'd0);
    checkOutput("rstMatchId", {31'd0, matchId}, 32'd0);
    checkOutput("rstAck", {31'd0, ack}, 32'd0);
    checkOutput("rstOut", {24'd0, outputBuffer}, 32'h00);
    checkOutput("rstTxValid", {31'd0, txValid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Four-byte write from pointer 1 wraps into byte 0.
    startC();
    sendAddr(7'h50, 1'b1);
    checkOutput("wrFound", {31'd0, addressFound}, 32'd1);
    checkOutput("wrAddrAck", {31'd0, ack}, 32'd1);
    checkOutput("wrMatchId", {31'd0, matchId}, 32'd0);
    sendByte(8'h01);
    checkOutput("wrPtrAck", {31'd0, ack}, 32'd1);
    sendByte(8'hAA); checkOutput("wrAckAA", {31'd0, ack}, 32'd1);
    sendByte(8'hBB); checkOutput("wrAckBB", {31'd0, ack}, 32'd1);
    sendByte(8'hCC); checkOutput("wrAckCC", {31'd0, ack}, 32'd1);
    sendByte(8'hDD); checkOutput("wrAckDD", {31'd0, ack}, 32'd1);
    stopC();
    checkOutput("stopClearsFound", {31'd0, addressFound}, 32'd0);

    pointedRead(7'h50, 8'h01);
    readByte(8'hAA);
    readByte(8'hBB);
    readByte(8'hCC);
    readByte(8'hDD);
    stopC();

    // Bank 1 write, then combined pointer/read; bank 0 must stay intact.
    startC();
    sendAddr(7'h51, 1'b1);
    sendByte(8'h00);
    sendByte(8'h11);
    stopC();
    pointedRead(7'h51, 8'h00);
    checkOutput("rdMatchId1", {31'd0, matchId}, 32'd1);
    readByte(8'h11);
    readByte(8'h00);
    sendByte(8'h5A);
    checkOutput("rxInReadNack", {31'd0, ack}, 32'd0);
    stopC();
    pointedRead(7'h50, 8'h00);
    readByte(8'hDD);
    stopC();

    // Foreign address: NACK, nothing stored, reads return 0xFF.
    startC();
    sendAddr(7'h3C, 1'b1);
    checkOutput("foreignFound", {31'd0, addressFound}, 32'd0);
    checkOutput("foreignAck", {31'd0, ack}, 32'd0);
    sendByte(8'h55);
    checkOutput("foreignByteAck", {31'd0, ack}, 32'd0);
    readByte(8'hFF);
    stopC();

    // Out-of-range pointer: NACK, following byte ignored, pointer kept at 1.
    startC();
    sendAddr(7'h50, 1'b1);
    sendByte(8'h07);
    checkOutput("badPtrAck", {31'd0, ack}, 32'd0);
    sendByte(8'h99);
    checkOutput("ignoredByteAck", {31'd0, ack}, 32'd0);
    stopC();
    startC();
    sendAddr(7'h50, 1'b0);
    readByte(8'hAA);
    stopC();

    // STOP coincident with a data byte drops the byte; pointer stays at 2.
    startC();
    sendAddr(7'h50, 1'b1);
    sendByte(8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 8'h77, 1'b0);
    checkOutput("stopRxFound", {31'd0, addressFound}, 32'd0);
    sendByte(8'h66);
    checkOutput("idleByteAck", {31'd0, ack}, 32'd0);
    readByte(8'hFF);
    startC();
    sendAddr(7'h50, 1'b0);
    readByte(8'hBB);
    stopC();

    // Reset in the middle of a bank 1 write clears everything at once.
    startC();
    sendAddr(7'h51, 1'b1);
    sendByte(8'h01);
    sendByte(8'h12);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstFound", {31'd0, addressFound}, 32'd0);
    checkOutput("midRstMatchId", {31'd0, matchId}, 32'd0);
    checkOutput("midRstAck", {31'd0, ack}, 32'd0);
    checkOutput("midRstOut", {24'd0, outputBuffer}, 32'h00);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    pointedRead(7'h50, 8'h00);
    readByte(8'h00);
    readByte(8'h00);
    stopC();
    pointedRead(7'h51, 8'h00);
    readByte(8'h00);
    readByte(8'h00);
    stopC();

    @(negedge clk);
    checkOutput("pendingTx", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regbank.md
I2C_SLAVE_REGBANK -- requirements
Module: i2c_slave_regbank

Interface
REQ-001 SHALL have parameter ADDRESSLENGTH, default 7, slave address width in bits.
REQ-002 SHALL have parameter ADDRESSNUM, default 4, number of device addresses served; each address owns a private byte bank.
REQ-003 SHALL have parameter NBYTES, default 16, bytes per bank; pointer width PW = clog2(NBYTES), minimum 1.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 ResetN  in  1  reset, asynchronous, active-low.
REQ-006 AddressList  in  ADDRESSLENGTH*ADDRESSNUM  packed slave addresses; entry i at bits [i*ADDRESSLENGTH +: ADDRESSLENGTH].
REQ-007 StartDet  in  1  one-cycle pulse on START or repeated START.
REQ-008 StopDet  in  1  one-cycle pulse on STOP.
REQ-009 AddrValid  in  1  one-cycle pulse; DirectionBuffer and RorW valid.
REQ-010 DirectionBuffer  in  ADDRESSLENGTH  received slave address.
REQ-011 RorW  in  1  1 = master writes into bank, 0 = master reads from bank.
REQ-012 RxValid  in  1  one-cycle pulse; InputBuffer holds a byte from master.
REQ-013 InputBuffer  in  8  received data byte.
REQ-014 TxReq  in  1  one-cycle pulse; engine requests next byte for master.
REQ-015 AddressFound  out  1  registered: current transaction addressed to this block.
REQ-016 MatchId  out  clog2(ADDRESSNUM)  index of matched AddressList entry.
REQ-017 Ack  out  1  registered ACK decision for last address/byte; 0 = NACK.
REQ-018 OutputBuffer  out  8  byte for master; valid when TxValid.
REQ-019 TxValid  out  1  one-cycle pulse one cycle after TxReq.

Function
REQ-020 States SHALL be IDLE, PTR, WRITE, READ, IGNORE.
REQ-021 AddrValid in any state SHALL compare DirectionBuffer against all ADDRESSNUM entries; lowest matching index wins.
REQ-022 On match, the cycle after AddrValid SHALL set AddressFound=1, Ack=1, MatchId=index; next state PTR if RorW=1, READ if RorW=0.
REQ-023 On no match, SHALL set AddressFound=0, Ack=0; next state IGNORE.
REQ-024 In PTR, RxValid SHALL load pointer from InputBuffer[PW-1:0], Ack=1, go to WRITE; if InputBuffer >= NBYTES, Ack=0, pointer unchanged, go to IGNORE.
REQ-025 In WRITE, RxValid SHALL store InputBuffer at bank[MatchId][pointer] on next edge, Ack=1, pointer increments.
REQ-026 In READ, TxReq SHALL drive OutputBuffer = bank[MatchId][pointer] with TxValid=1 next cycle; pointer increments.
REQ-027 Pointer increment SHALL wrap NBYTES-1 -> 0 within the same bank; no spill into adjacent bank.
REQ-028 Pointer SHALL be retained across repeated START (combined write-pointer/read format) and across STOP.
REQ-029 In IGNORE and IDLE, RxValid and TxReq SHALL not modify storage or pointer; Ack=0; TxReq returns OutputBuffer=8'hFF with TxValid=1.
REQ-030 StopDet SHALL go to IDLE and clear AddressFound; StartDet SHALL go to IDLE awaiting AddrValid.
REQ-031 StopDet/StartDet coincident with RxValid or TxReq: Stop/Start wins; byte dropped, pointer unchanged.
REQ-032 RxValid in READ or TxReq in PTR/WRITE is a protocol error: ignored, Ack=0, state unchanged.
REQ-033 AddressList changes SHALL take effect only at the next AddrValid.

Reset
REQ-034 ResetN low SHALL immediately force state IDLE, pointer 0, all bank bytes 8'h00, AddressFound=0, MatchId=0, Ack=0, OutputBuffer=8'h00, TxValid=0.
REQ-035 Reset asserted mid-transaction SHALL abort it; after release, block waits for AddrValid with no partial write committed.

Structure
REQ-036 Shared package i2c_slave_pkg SHALL hold state encoding, default ADDRESSLENGTH and a clog2 function.
REQ-037 Address comparison SHALL be sub-module i2c_addr_match (combinational priority matcher, outputs hit and index); registers live in the top.

Verification (ADDRESSLENGTH=7, ADDRESSNUM=2, NBYTES=4, AddressList={7'h51,7'h50})
REQ-038 Addr 7'h50 RorW=1, ptr 8'h01, data AA,BB,CC,DD -> bank0[1..3,0]=AA,BB,CC,DD (wrap), Ack=1 each.
REQ-039 Addr 7'h51 RorW=1, ptr 0, data 11; repeated START, 7'h51 RorW=0, two TxReq -> OutputBuffer 11 then bank1[1]=00; bank0 untouched.
REQ-040 Addr 7'h3C -> AddressFound=0, Ack=0; following RxValid 8'h55 -> no storage change, Ack=0.
REQ-041 Addr 7'h50 write, ptr 8'h07 -> Ack=0, IGNORE; next byte not stored.
REQ-042 StopDet same cycle as RxValid 8'h77 in WRITE -> byte dropped, state IDLE, pointer unchanged.
REQ-043 ResetN low mid-WRITE -> all outputs and banks zero immediately, subsequent read of 7'h50 ptr 0 returns 8'h00.
